// File: rtl/adder_sequencer.sv
// adder_sequencer: word-serial controller for an external WIDTH-bit adder cell
// (Addierzelle). Latches two WORDS*WIDTH-bit operands on START and steps them
// through the cell least-significant word first. The carry chains through a
// register between words. The full sum and final carry are presented with a
// one-cycle DONE pulse.
module adder_sequencer #(
    parameter int WIDTH = 10,
    parameter int WORDS = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [WIDTH*WORDS-1:0]   A_IN,
    input  logic [WIDTH*WORDS-1:0]   B_IN,
    input  logic                     C_IN,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [WIDTH*WORDS-1:0]   S_OUT,
    output logic                     C_OUT,
    output logic [WIDTH-1:0]         ADD_A,
    output logic [WIDTH-1:0]         ADD_B,
    output logic                     ADD_C_IN,
    input  logic [WIDTH-1:0]         ADD_S,
    input  logic                     ADD_C_OUT
);

    localparam int TOTAL_W = WIDTH * WORDS;
    // Index needs at least one bit even when WORDS == 1.
    localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 carry_q;
    logic [TOTAL_W-1:0]   op_a_q;
    logic [TOTAL_W-1:0]   op_b_q;
    logic [TOTAL_W-1:0]   res_q;
    logic [TOTAL_W-1:0]   res_d;
    logic [TOTAL_W-1:0]   s_out_q;
    logic                 c_out_q;
    logic                 busy_q;
    logic                 done_q;

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign S_OUT = s_out_q;
    assign C_OUT = c_out_q;

    // Drive the shared adder cell with the current word only while running.
    always_comb begin
        ADD_A    = '0;
        ADD_B    = '0;
        ADD_C_IN = 1'b0;
        if (state_q == ST_RUN) begin
            ADD_A    = op_a_q[idx_q*WIDTH +: WIDTH];
            ADD_B    = op_b_q[idx_q*WIDTH +: WIDTH];
            ADD_C_IN = carry_q;
        end else begin
            ADD_A    = '0;
            ADD_B    = '0;
            ADD_C_IN = 1'b0;
        end
    end

    // Result with the cell's sum merged into the current word slot; this is
    // also what S_OUT captures on the last word so the final word is included.
    always_comb begin
        res_d = res_q;
        if (state_q == ST_RUN) begin
            res_d[idx_q*WIDTH +: WIDTH] = ADD_S;
        end else begin
            res_d = res_q;
        end
    end

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            s_out_q <= '0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        op_a_q  <= A_IN;
                        op_b_q  <= B_IN;
                        carry_q <= C_IN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    res_q   <= res_d;
                    carry_q <= ADD_C_OUT;
                    if (idx_q == LAST_IDX) begin
                        // Last word: publish result, park the index at 0
                        // rather than letting it wrap.
                        idx_q   <= '0;
                        s_out_q <= res_d;
                        c_out_q <= ADD_C_OUT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // START is ignored here; it is not queued.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sequencer.sv
// Testbench for adder_sequencer: directed vectors with hand-computed sums,
// a behavioural adder cell, and a scoreboard monitor checking each DONE.
module tb_adder_sequencer;

    localparam int W  = 10;
    localparam int N  = 4;
    localparam int TW = W * N;

    typedef struct {
        logic [TW-1:0] sum;
        logic          cout;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [TW-1:0] a_in;
    logic [TW-1:0] b_in;
    logic          c_in;
    logic          busy;
    logic          done;
    logic [TW-1:0] s_out;
    logic          c_out;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_c_in;
    logic [W-1:0]  add_s;
    logic          add_c_out;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [TW-1:0] prev_s = '0;
    logic          prev_c = 1'b0;

    adder_sequencer #(.WIDTH(W), .WORDS(N)) dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .A_IN      (a_in),
        .B_IN      (b_in),
        .C_IN      (c_in),
        .BUSY      (busy),
        .DONE      (done),
        .S_OUT     (s_out),
        .C_OUT     (c_out),
        .ADD_A     (add_a),
        .ADD_B     (add_b),
        .ADD_C_IN  (add_c_in),
        .ADD_S     (add_s),
        .ADD_C_OUT (add_c_out)
    );

    // Behavioural Addierzelle
    assign {add_c_out, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every DONE pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got DONE=1 expected no pending result");
                end else begin
                    e = exp_q.pop_front();
                    check("sum", s_out, e.sum);
                    check("cout", {{(TW-1){1'b0}}, c_out}, {{(TW-1){1'b0}}, e.cout});
                end
            end
        end
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000 expected finish");
        $fatal(1, "timeout");
    end

    // Run one addition; optionally pulse START with junk operands during RUN and DONE.
    task automatic do_add(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic ci,
                          input logic [TW-1:0] exp_sum, input logic exp_c, input bit noise);
        exp_t e;
        logic [TW:0] lo;
        logic [TW-1:0] mask;
        logic exp_ci;
        @(posedge clk);
        #1;
        a_in = a; b_in = b; c_in = ci; start = 1'b1;
        @(posedge clk);            // edge k: START sampled
        #1;
        start = 1'b0;
        e.sum = exp_sum; e.cout = exp_c;
        exp_q.push_back(e);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            mask = (i == 0) ? '0 : ({TW{1'b1}} >> (TW - i*W));
            lo = {1'b0, a & mask} + {1'b0, b & mask} + {{TW{1'b0}}, ci};
            exp_ci = lo[i*W];
            check("run_busy", {{(TW-1){1'b0}}, busy}, {{(TW-1){1'b0}}, 1'b1});
            check("run_done", {{(TW-1){1'b0}}, done}, '0);
            check("run_hold_s", s_out, prev_s);
            check("run_hold_c", {{(TW-1){1'b0}}, c_out}, {{(TW-1){1'b0}}, prev_c});
            check("add_a", {{(TW-W){1'b0}}, add_a}, (a >> (i*W)) & {{(TW-W){1'b0}}, {W{1'b1}}});
            check("add_b", {{(TW-W){1'b0}}, add_b}, (b >> (i*W)) & {{(TW-W){1'b0}}, {W{1'b1}}});
            check("add_c_in", {{(TW-1){1'b0}}, add_c_in}, {{(TW-1){1'b0}}, exp_ci});
            if (noise && i == 1) begin
                start = 1'b1; a_in = {TW{1'b1}}; b_in = {TW{1'b1}}; c_in = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);            // DONE cycle (monitor compares result)
        check("done_pulse", {{(TW-1){1'b0}}, done}, {{(TW-1){1'b0}}, 1'b1});
        check("done_busy", {{(TW-1){1'b0}}, busy}, '0);
        check("done_add_a", {{(TW-W){1'b0}}, add_a}, '0);
        if (noise) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);            // back in IDLE; a START in DONE must not restart
        check("idle_done", {{(TW-1){1'b0}}, done}, '0);
        check("idle_busy", {{(TW-1){1'b0}}, busy}, '0);
        prev_s = exp_sum;
        prev_c = exp_c;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy0", {{(TW-1){1'b0}}, busy}, '0);
            check("idle_done0", {{(TW-1){1'b0}}, done}, '0);
            check("idle_s0", s_out, '0);
            check("idle_c0", {{(TW-1){1'b0}}, c_out}, '0);
            check("idle_add_a0", {{(TW-W){1'b0}}, add_a}, '0);
            check("idle_add_b0", {{(TW-W){1'b0}}, add_b}, '0);
        end

        // Basic sum
        do_add(40'h00000_00123, 40'h00000_00456, 1'b0, 40'h00000_00579, 1'b0, 1'b0);
        // Full carry ripple
        do_add(40'hFF_FFFF_FFFF, 40'h00_0000_0000, 1'b1, 40'h00_0000_0000, 1'b1, 1'b0);
        // Overflow with carry in
        do_add(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, 40'hFF_FFFF_FFFF, 1'b1, 1'b0);
        // START ignored while busy, then a normal addition
        do_add(40'h00_0001_2345, 40'h00_0000_ABCD, 1'b0, 40'h00_0001_CF12, 1'b0, 1'b1);
        do_add(40'h80_0000_0000, 40'h80_0000_0000, 1'b0, 40'h00_0000_0000, 1'b1, 1'b0);

        // Reset mid-operation
        @(posedge clk);
        #1;
        a_in = 40'd5; b_in = 40'd7; c_in = 1'b0; start = 1'b1;
        @(posedge clk);            // edge k
        #1;
        start = 1'b0;
        @(posedge clk);            // edge k+1: now in 2nd RUN cycle
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {{(TW-1){1'b0}}, busy}, '0);
        check("rst_s", s_out, '0);
        check("rst_c", {{(TW-1){1'b0}}, c_out}, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_done", {{(TW-1){1'b0}}, done}, '0);
        end
        prev_s = '0;
        prev_c = 1'b0;
        do_add(40'd1, 40'd1, 1'b0, 40'd2, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", TW'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
